// File: rtl/planificador_tx_alertas.sv
// TX-line scheduler for the monitor's MAX transceiver link: derives the baud tick,
// arbitrates periodic status frames against urgent alarm frames and serialises them.
module planificador_tx_alertas #(
  parameter int CLK_DIV        = 41667,
  parameter int PERIODO_ESTADO = 1200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       humo,
  input  logic       pos,
  input  logic       temp_grave,
  input  logic       temp_leve,
  input  logic       frec,
  input  logic       alarma_leve,
  input  logic       alarma_grave,
  input  logic       habilitar,
  output logic       tx_serie,
  output logic       ocupado,
  output logic       tipo_trama,
  output logic [3:0] perdidas
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PER_W = $clog2(PERIODO_ESTADO);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_MAX = PER_W'(PERIODO_ESTADO - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GUARD = 3'd4
  } estado_t;

  estado_t          estado;
  logic [DIV_W-1:0] div_cnt;
  logic [PER_W-1:0] per_cnt;
  logic             pend_estado;
  logic             pend_alarma;
  logic             nivel_q;
  logic [7:0]       sr;
  logic [2:0]       bit_idx;

  logic       tick;
  logic       wrap;
  logic       nivel_alarma;
  logic       flanco;
  logic       puede_lanzar;
  logic       lanza_alarma;
  logic       lanza_estado;
  logic       lanza;
  logic [6:0] datos;

  assign tick         = (div_cnt == DIV_MAX);
  assign wrap         = tick && (per_cnt == PER_MAX);
  assign nivel_alarma = alarma_leve | alarma_grave;
  assign flanco       = nivel_alarma & ~nivel_q;
  assign datos        = {alarma_grave, alarma_leve, frec, temp_leve, temp_grave, pos, humo};

  // GUARD's closing tick takes the same launch decision as IDLE, so a queued
  // request leaves back to back and a frame pair spans exactly 22 bit times.
  assign puede_lanzar = tick && habilitar && ((estado == IDLE) || (estado == GUARD));
  assign lanza_alarma = puede_lanzar && pend_alarma;
  assign lanza_estado = puede_lanzar && !pend_alarma && (pend_estado || wrap);
  assign lanza        = lanza_alarma || lanza_estado;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A wrap arriving while a status request is already pending is simply absorbed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt     <= '0;
      pend_estado <= 1'b0;
    end else begin
      if (tick) begin
        per_cnt <= wrap ? '0 : per_cnt + 1'b1;
      end
      if (lanza_estado) begin
        pend_estado <= 1'b0;
      end else if (wrap) begin
        pend_estado <= 1'b1;
      end
    end
  end

  // The edge register loads the live level in reset so an alarm already high at
  // release does not count as a new event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nivel_q     <= alarma_leve | alarma_grave;
      pend_alarma <= 1'b0;
      perdidas    <= 4'd0;
    end else begin
      nivel_q     <= nivel_alarma;
      pend_alarma <= flanco | (pend_alarma & ~lanza_alarma);
      if (flanco && pend_alarma && !lanza_alarma && (perdidas != 4'hF)) begin
        perdidas <= perdidas + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= IDLE;
      sr         <= 8'd0;
      bit_idx    <= 3'd0;
      tx_serie   <= 1'b1;
      ocupado    <= 1'b0;
      tipo_trama <= 1'b0;
    end else if (tick) begin
      case (estado)
        IDLE, GUARD: begin
          if (lanza) begin
            sr         <= {lanza_alarma, datos};
            tipo_trama <= lanza_alarma;
            tx_serie   <= 1'b0;
            ocupado    <= 1'b1;
            estado     <= START;
          end else begin
            tx_serie <= 1'b1;
            ocupado  <= 1'b0;
            estado   <= IDLE;
          end
        end
        START: begin
          tx_serie <= sr[0];
          sr       <= {1'b0, sr[7:1]};
          bit_idx  <= 3'd0;
          estado   <= DATA;
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
            tx_serie <= 1'b1;
            estado   <= STOP;
          end else begin
            tx_serie <= sr[0];
            sr       <= {1'b0, sr[7:1]};
            bit_idx  <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          tx_serie <= 1'b1;
          estado   <= GUARD;
        end
        default: begin
          tx_serie <= 1'b1;
          ocupado  <= 1'b0;
          estado   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_planificador_tx_alertas.sv
// Directed bench for planificador_tx_alertas with CLK_DIV = 4 and PERIODO_ESTADO = 20:
// baud tick n lands on clock edge 4n after reset release, so status wraps fall on cycles 80k.
module tb_planificador_tx_alertas;

  logic       clk;
  logic       reset_n;
  logic       humo, pos, temp_grave, temp_leve, frec;
  logic       alarma_leve, alarma_grave, habilitar;
  logic       tx_serie, ocupado, tipo_trama;
  logic [3:0] perdidas;

  int n_chk;
  int n_err;
  int cyc;

  typedef struct {
    logic [4:0] sens;        // {frec, temp_leve, temp_grave, pos, humo}
    logic [1:0] alm;         // {alarma_grave, alarma_leve}
    logic [7:0] exp_status;
    logic [7:0] exp_alarm;
  } vec_t;

  vec_t tabla[4];

  planificador_tx_alertas #(
    .CLK_DIV        (4),
    .PERIODO_ESTADO (20)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .humo         (humo),
    .pos          (pos),
    .temp_grave   (temp_grave),
    .temp_leve    (temp_leve),
    .frec         (frec),
    .alarma_leve  (alarma_leve),
    .alarma_grave (alarma_grave),
    .habilitar    (habilitar),
    .tx_serie     (tx_serie),
    .ocupado      (ocupado),
    .tipo_trama   (tipo_trama),
    .perdidas     (perdidas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns 1 time unit after clock edge n (counted from reset release).
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 5000) begin
        n_err++;
        $display("FAIL wait_cyc: timeout at cyc %0d waiting for %0d", cyc, n);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic set_sens(input logic [4:0] s);
    {frec, temp_leve, temp_grave, pos, humo} = s;
  endtask

  task automatic check_idle(input string name, input int from, input int to);
    bit ok;
    ok = 1'b1;
    for (int c = from; c <= to; c++) begin
      wait_cyc(c);
      #3;
      if (tx_serie !== 1'b1 || ocupado !== 1'b0) ok = 1'b0;
    end
    chk(name, {15'd0, ok}, 16'd1);
  endtask

  // Samples each of the 11 bit times of a frame expected to leave at cycle start.
  task automatic check_frame(input string name, input int start, input logic [7:0] exp_d,
                             input logic exp_tipo, input bit b2b, input bit drop_hab);
    logic [10:0] cap;
    logic [10:0] exp_bits;
    bit          occ_ok;
    exp_bits = {2'b11, exp_d, 1'b0};
    cap      = '0;
    occ_ok   = 1'b1;
    wait_cyc(start - 1);
    #3;
    chk({name, "_pre_high"}, {15'd0, tx_serie}, 16'd1);
    for (int b = 0; b < 11; b++) begin
      wait_cyc(start + 4 * b + 2);
      #3;
      cap[b] = tx_serie;
      if (ocupado !== 1'b1) occ_ok = 1'b0;
      if (b == 0) chk({name, "_tipo"}, {15'd0, tipo_trama}, {15'd0, exp_tipo});
      if (drop_hab && b == 3) habilitar = 1'b0;
    end
    chk({name, "_bits"}, {5'd0, cap}, {5'd0, exp_bits});
    wait_cyc(start + 43);
    #3;
    if (ocupado !== 1'b1) occ_ok = 1'b0;
    chk({name, "_ocupado"}, {15'd0, occ_ok}, 16'd1);
    if (!b2b) begin
      wait_cyc(start + 44);
      #3;
      chk({name, "_end"}, {14'd0, ocupado, tx_serie}, 16'h0001);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0;
    habilitar = 1'b0;
    alarma_leve = 1'b0;
    alarma_grave = 1'b0;
    set_sens(5'b00000);

    tabla[0] = '{sens: 5'b00011, alm: 2'b10, exp_status: 8'h03, exp_alarm: 8'hC3};
    tabla[1] = '{sens: 5'b10100, alm: 2'b01, exp_status: 8'h14, exp_alarm: 8'hB4};
    tabla[2] = '{sens: 5'b01000, alm: 2'b11, exp_status: 8'h08, exp_alarm: 8'hE8};
    tabla[3] = '{sens: 5'b00000, alm: 2'b10, exp_status: 8'h00, exp_alarm: 8'hC0};

    // Reset state
    #22;
    chk("rst_tx", {15'd0, tx_serie}, 16'd1);
    chk("rst_ocupado", {15'd0, ocupado}, 16'd0);
    chk("rst_tipo", {15'd0, tipo_trama}, 16'd0);
    chk("rst_perdidas", {12'd0, perdidas}, 16'd0);

    // Each entry: status at base, alarm at base+48, status back to back at base+92
    habilitar = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      int base;
      base = 80 + 160 * i;
      wait_cyc(base - 20);
      set_sens(tabla[i].sens);
      check_frame($sformatf("v%0d_status", i), base, tabla[i].exp_status, 1'b0, 1'b0, 1'b0);
      wait_cyc(base + 45);
      {alarma_grave, alarma_leve} = tabla[i].alm;
      check_frame($sformatf("v%0d_alarm", i), base + 48, tabla[i].exp_alarm, 1'b1, 1'b1, 1'b0);
      wait_cyc(base + 91);
      {alarma_grave, alarma_leve} = 2'b00;
      check_frame($sformatf("v%0d_status_b2b", i), base + 92, tabla[i].exp_status, 1'b0, 1'b0, 1'b0);
    end

    // Alarm and status wrap on the same tick; habilitar dropped mid status frame
    set_sens(5'b00000);
    alarma_leve = 1'b0;
    alarma_grave = 1'b0;
    habilitar = 1'b1;
    apply_reset();
    wait_cyc(77);
    alarma_leve = 1'b1;
    check_frame("coll_alarm", 80, 8'hA0, 1'b1, 1'b1, 1'b0);
    check_frame("coll_status", 124, 8'h20, 1'b0, 1'b0, 1'b1);
    wait_cyc(170);
    alarma_leve = 1'b0;
    wait_cyc(175);
    alarma_grave = 1'b1;
    check_idle("hab_off_idle", 176, 260);
    wait_cyc(261);
    habilitar = 1'b1;
    check_frame("hab_on_alarm", 264, 8'hC0, 1'b1, 1'b1, 1'b0);
    check_frame("hab_on_status", 308, 8'h40, 1'b0, 1'b1, 1'b0);

    // Dropped alarm events and saturation
    alarma_leve = 1'b0;
    alarma_grave = 1'b0;
    habilitar = 1'b1;
    apply_reset();
    wait_cyc(5);
    alarma_leve = 1'b1;
    wait_cyc(20);
    alarma_leve = 1'b0;
    wait_cyc(22);
    alarma_leve = 1'b1;
    wait_cyc(24);
    alarma_leve = 1'b0;
    wait_cyc(26);
    alarma_leve = 1'b1;
    wait_cyc(30);
    #3;
    chk("drop_one", {12'd0, perdidas}, 16'd1);
    check_frame("drop_realarm", 52, 8'hA0, 1'b1, 1'b1, 1'b0);
    check_frame("drop_status", 96, 8'h20, 1'b0, 1'b0, 1'b0);
    check_idle("drop_no_third", 141, 156);
    wait_cyc(157);
    habilitar = 1'b0;
    for (int k = 0; k < 17; k++) begin
      wait_cyc(158 + 4 * k);
      alarma_leve = 1'b0;
      wait_cyc(160 + 4 * k);
      alarma_leve = 1'b1;
      if (k == 14) begin
        wait_cyc(220);
        #3;
        chk("drop_reach15", {12'd0, perdidas}, 16'd15);
      end
    end
    wait_cyc(228);
    #3;
    chk("drop_saturate", {12'd0, perdidas}, 16'd15);

    // Asynchronous reset during DATA bit 3 of an alarm frame
    wait_cyc(300);
    habilitar = 1'b1;
    wait_cyc(321);
    chk("mid_bit3_tx", {15'd0, tx_serie}, 16'd0);
    chk("mid_bit3_ocupado", {15'd0, ocupado}, 16'd1);
    reset_n = 1'b0;
    #1;
    chk("async_tx", {15'd0, tx_serie}, 16'd1);
    chk("async_ocupado", {15'd0, ocupado}, 16'd0);
    chk("async_perdidas", {12'd0, perdidas}, 16'd0);
    chk("async_tipo", {15'd0, tipo_trama}, 16'd0);
    apply_reset();
    check_idle("post_rst_idle", 1, 78);
    check_frame("post_rst_status", 80, 8'h20, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
